// File: rtl/pio_edge_master.sv
// Avalon-MM master that services a 4-bit edge-capturing PIO: it programs the irq mask, then reads and clears captures and emits them as events.
// Optional interval polling when PIO_EDGE_MASTER_POLL_EN is defined.
module pio_edge_master #(
  parameter int                WIDTH       = 4,
  parameter logic [WIDTH-1:0]  IRQ_MASK    = {WIDTH{1'b1}},
  parameter int                POLL_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [WIDTH-1:0] avm_writedata,
  input  logic [WIDTH-1:0] avm_readdata,
  input  logic             pio_irq,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_level,
  output logic             busy
);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    RD_EDGE = 3'd2,
    WT_EDGE = 3'd3,
    CLR     = 3'd4,
    RD_LVL  = 3'd5,
    WT_LVL  = 3'd6,
    EMIT    = 3'd7
  } state_t;

  state_t state;
  state_t nxt;
  logic   poll_hit;

`ifdef PIO_EDGE_MASTER_POLL_EN
  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  logic [PW-1:0] poll_cnt;

  assign poll_hit = (poll_cnt == PW'(POLL_CYCLES - 1));

  // Poll interval counter: counts only while parked in IDLE, clears on any exit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
    end else if (state != IDLE || nxt != IDLE) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + PW'(1);
    end
  end
`else
  logic unused_poll;
  assign poll_hit    = 1'b0;
  assign unused_poll = (POLL_CYCLES != 0);
`endif

  // Next-state decode.
  always_comb begin
    nxt = state;
    case (state)
      INIT:    nxt = IDLE;
      IDLE: begin
        if (pio_irq || poll_hit) nxt = RD_EDGE;
        else                     nxt = IDLE;
      end
      RD_EDGE: nxt = WT_EDGE;
      WT_EDGE: begin
        if (|avm_readdata) nxt = CLR;
        else               nxt = IDLE;
      end
      CLR:     nxt = RD_LVL;
      RD_LVL:  nxt = WT_LVL;
      WT_LVL:  nxt = EMIT;
      EMIT: begin
        if (evt_ready) nxt = IDLE;
        else           nxt = EMIT;
      end
      default: nxt = INIT;
    endcase
  end

  // State and registered outputs. Outputs are loaded from the next state so the
  // bus always shows the action of the state being entered; INIT is the
  // exception, issuing its mask write on the first edge out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= INIT;
      avm_address    <= 2'd0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      evt_valid      <= 1'b0;
      evt_edges      <= '0;
      evt_level      <= '0;
      busy           <= 1'b1;
    end else begin
      state          <= nxt;
      busy           <= (state == INIT) ? 1'b1 : (nxt != IDLE);
      evt_valid      <= (nxt == EMIT);
      avm_address    <= 2'd0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      if (state == WT_EDGE) evt_edges <= avm_readdata;
      if (state == WT_LVL)  evt_level <= avm_readdata;
      if (state == INIT) begin
        avm_address    <= 2'd2;
        avm_chipselect <= 1'b1;
        avm_write_n    <= 1'b0;
        avm_writedata  <= IRQ_MASK;
      end else begin
        case (nxt)
          RD_EDGE: begin
            avm_address    <= 2'd3;
            avm_chipselect <= 1'b1;
          end
          WT_EDGE: avm_address <= 2'd3;
          CLR: begin
            avm_address    <= 2'd3;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
          end
          RD_LVL:  avm_chipselect <= 1'b1;
          default: avm_address    <= 2'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pio_edge_master.sv
// Bench for pio_edge_master: PIO slave model, transaction/event scoreboard and directed scenarios.
module tb_pio_edge_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] avm_address;
  logic       avm_chipselect;
  logic       avm_write_n;
  logic [3:0] avm_writedata;
  logic [3:0] avm_readdata = 4'h0;
  logic       pio_irq;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_edges;
  logic [3:0] evt_level;
  logic       busy;

  pio_edge_master #(.WIDTH(4), .IRQ_MASK(4'hF), .POLL_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .pio_irq(pio_irq),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_edges(evt_edges), .evt_level(evt_level), .busy(busy)
  );

  always #5 clk = ~clk;

  // PIO slave model: levels, irq mask, edge capture cleared by any write to addr 3.
  logic [3:0] lvl = 4'h0;
  logic [3:0] edge_set = 4'h0;
  logic [3:0] edge_cap = 4'h0;
  logic [3:0] mask = 4'h0;
  logic       force_irq = 1'b0;
  logic       irq_tie0 = 1'b0;

  assign pio_irq = !irq_tie0 && ((|(edge_cap & mask)) || force_irq);

  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n)
      avm_readdata <= (avm_address == 2'd0) ? lvl :
                      (avm_address == 2'd2) ? mask :
                      (avm_address == 2'd3) ? edge_cap : 4'h0;
    if (avm_chipselect && !avm_write_n && avm_address == 2'd2) mask <= avm_writedata;
    if (avm_chipselect && !avm_write_n && avm_address == 2'd3) edge_cap <= edge_set;
    else edge_cap <= edge_cap | edge_set;
  end

  // Scoreboard: expected bus transfers {is_write, addr, wdata} and events {edges, level}.
  localparam logic [6:0] RD3 = {1'b0, 2'd3, 4'h0};
  localparam logic [6:0] WR3 = {1'b1, 2'd3, 4'h0};
  localparam logic [6:0] RD0 = {1'b0, 2'd0, 4'h0};
  localparam logic [6:0] WRM = {1'b1, 2'd2, 4'hF};
  logic [6:0] exp_bus[$];
  logic [7:0] exp_ev[$];
  int cmp = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    cmp++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_xfer(input logic [6:0] got);
    if (exp_bus.size() == 0) begin
      chk("unexpected_xfer", {25'd0, got}, 32'h7F);
    end else begin
      chk("bus_xfer", {25'd0, got}, {25'd0, exp_bus.pop_front()});
    end
  endtask

  // A full service of one capture: read edges, clear, read levels, one event.
  task automatic svc(input logic [3:0] e, input logic [3:0] l);
    exp_bus.push_back(RD3);
    exp_bus.push_back(WR3);
    exp_bus.push_back(RD0);
    exp_ev.push_back({e, l});
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic inject(input logic [3:0] bits);
    edge_set = bits;
    tick;
    edge_set = 4'h0;
  endtask

  task automatic wait_ev_empty(input string name);
    int n = 0;
    while (exp_ev.size() != 0 && n < 60) begin
      tick;
      n++;
    end
    chk(name, exp_ev.size(), 0);
  endtask

  // Compare process; an edge-capture read is judged one cycle later so a
  // zero-result poll read can be told apart.
  initial begin : cmp_proc
    logic       pend_rd3;
    logic       prev_valid;
    logic [3:0] prev_e;
    logic [3:0] prev_l;
    logic [7:0] ev;
    pend_rd3   = 1'b0;
    prev_valid = 1'b0;
    prev_e     = 4'h0;
    prev_l     = 4'h0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend_rd3   = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (pend_rd3) begin
          pend_rd3 = 1'b0;
`ifdef PIO_EDGE_MASTER_POLL_EN
          if (avm_readdata != 4'h0) check_xfer(RD3);
`else
          check_xfer(RD3);
`endif
        end
        if (avm_chipselect) begin
          if (avm_write_n && avm_address == 2'd3) pend_rd3 = 1'b1;
          else check_xfer({!avm_write_n, avm_address, avm_write_n ? 4'h0 : avm_writedata});
        end
        if (evt_valid) chk("no_bus_in_emit", {31'd0, avm_chipselect}, 32'd0);
        if (prev_valid && evt_valid) chk("evt_stable", {24'd0, evt_edges, evt_level}, {24'd0, prev_e, prev_l});
        if (evt_valid && evt_ready) begin
          if (exp_ev.size() == 0) begin
            chk("unexpected_event", {24'd0, evt_edges, evt_level}, 32'hFFFF);
          end else begin
            ev = exp_ev.pop_front();
            chk("event", {24'd0, evt_edges, evt_level}, {24'd0, ev});
          end
        end
        prev_valid = evt_valid && !evt_ready;
        prev_e     = evt_edges;
        prev_l     = evt_level;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    reset_n   = 1'b0;
    evt_ready = 1'b1;
    repeat (3) tick;
    chk("rst_addr", avm_address, 2'd0);
    chk("rst_cs", avm_chipselect, 1'b0);
    chk("rst_wn", avm_write_n, 1'b1);
    chk("rst_wd", avm_writedata, 4'h0);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_edges_level", {evt_edges, evt_level}, 8'h00);
    chk("rst_busy", busy, 1'b1);

    // Reset release: one mask write, then idle.
    exp_bus.push_back(WRM);
    reset_n = 1'b1;
    tick;
    chk("init_write", {avm_chipselect, avm_write_n, avm_address, avm_writedata}, {1'b1, 1'b0, 2'd2, 4'hF});
    chk("init_busy", busy, 1'b1);
    tick;
    chk("idle_cs", avm_chipselect, 1'b0);
    chk("idle_busy", busy, 1'b0);
    repeat (3) tick;
    chk("slave_mask", mask, 4'hF);

    // Edge on bit 1 with levels 1101, measuring irq-to-valid latency.
    lvl = 4'b1101;
    svc(4'b0010, 4'b1101);
    inject(4'b0010);
    chk("irq_raised", pio_irq, 1'b1);
    n = 0;
    while (!evt_valid && n < 20) begin
      tick;
      n++;
    end
`ifdef PIO_EDGE_MASTER_POLL_EN
    chk("latency", (n == 5 || n == 6) ? 32'd6 : n, 32'd6);
`else
    chk("latency", n, 32'd6);
`endif
    chk("evt_edges_lit", evt_edges, 4'b0010);
    chk("evt_level_lit", evt_level, 4'b1101);
    tick;
    tick;
    chk("cap_cleared", edge_cap, 4'h0);
    chk("valid_dropped", evt_valid, 1'b0);

    // Backpressure: event 1 held for 20 cycles while a second edge arrives.
    evt_ready = 1'b0;
    lvl = 4'b0100;
    svc(4'b0100, 4'b0100);
    svc(4'b1000, 4'b1010);
    inject(4'b0100);
    n = 0;
    while (!evt_valid && n < 20) begin
      tick;
      n++;
    end
    chk("bp_valid", evt_valid, 1'b1);
    inject(4'b1000);
    lvl = 4'b1010;
    repeat (20) tick;
    chk("bp_hold", {evt_valid, pio_irq, evt_edges}, {1'b1, 1'b1, 4'b0100});
    evt_ready = 1'b1;
    wait_ev_empty("bp_drain");

    // Spurious irq: read of capture only, no clear, no event.
`ifndef PIO_EDGE_MASTER_POLL_EN
    exp_bus.push_back(RD3);
`endif
    force_irq = 1'b1;
    tick;
    force_irq = 1'b0;
    repeat (10) tick;
    chk("spur_idle", {busy, evt_valid}, 2'b00);

    // Reset pulsed during the clear write.
    lvl = 4'b0111;
    exp_bus.push_back(RD3);
    inject(4'b0001);
    n = 0;
    while (!(avm_chipselect && avm_write_n && avm_address == 2'd3) && n < 20) begin
      tick;
      n++;
    end
    chk("rst_rd3_seen", avm_chipselect, 1'b1);
    tick;
    tick;
    chk("in_clr", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b0, 2'd3});
    reset_n = 1'b0;
    #1;
    chk("mid_rst_bus", {avm_chipselect, avm_write_n, avm_address}, {1'b0, 1'b1, 2'd0});
    chk("mid_rst_out", {evt_valid, busy}, 2'b01);
    exp_bus.push_back(WRM);
    svc(4'b0001, 4'b0111);
    repeat (2) tick;
    reset_n = 1'b1;
    wait_ev_empty("rst_rerun");
    chk("rst_cap_cleared", edge_cap, 4'h0);

    // Interrupt tied off: only polling may find the edge.
    irq_tie0 = 1'b1;
    lvl = 4'b0011;
`ifdef PIO_EDGE_MASTER_POLL_EN
    svc(4'b0001, 4'b0011);
    inject(4'b0001);
    n = 0;
    while (!(avm_chipselect && avm_write_n && avm_address == 2'd3) && n < 40) begin
      tick;
      n++;
    end
    chk("poll_within_16", (n <= 17) ? 32'd1 : 32'd0, 32'd1);
    wait_ev_empty("poll_event");
`else
    inject(4'b0001);
    repeat (40) tick;
    chk("no_poll_idle", {busy, edge_cap}, {1'b0, 4'b0001});
    svc(4'b0001, 4'b0011);
    irq_tie0 = 1'b0;
    wait_ev_empty("late_irq_event");
`endif
    irq_tie0 = 1'b0;
    repeat (4) tick;
    chk("bus_q_empty", exp_bus.size(), 0);
    chk("ev_q_empty", exp_ev.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
